masked_share_sequencer: RTL and testbench
=========================================

// Module: masked_share_sequencer
// PURPOSE
//  Parametrised control FSM for the masked S-box datapath. One start request drives a
//  complete sequence: divide, then one adjust/refresh pass per share, then the
//  address/output phase. The block sits between the round controller and the share
//  datapath, and adds start/busy/done handshaking, abort, a configurable share count
//  and a configurable refresh length.
// PARAMETERS
//  SHARES          4  number of shares processed; legal range 2..2**IDX_W
//  IDX_W           3  width of adjust_idx
//  REFRESH_CYCLES  1  cycles refresh_en is held per share; must be >=1
//  AUTO_RESTART    0  1: DONE goes straight to DIVIDE without start (free-running)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, synchronous, active-high
//  start       in   1      sequence request, sampled in IDLE and DONE only
//  abort       in   1      synchronous abort; FSM returns to IDLE next cycle
//  busy        out  1      high in DIVIDE, ADJUST, REFRESH and ADDRESS
//  done        out  1      one-cycle pulse in DONE
//  divide_en   out  1      high in DIVIDE
//  adjust_en   out  1      high in ADJUST
//  adjust_idx  out  IDX_W  share index in use (k); 0 in IDLE
//  refresh_en  out  1      high in REFRESH
//  address_en  out  1      high in ADDRESS
// BEHAVIOUR
//  - Moore FSM. All outputs decode from registered state, share counter k and refresh
//    counter r. No output depends combinationally on any input.
//  - Reset: state=IDLE, k=0, r=0; every output is 0 in the first cycle after rst.
//    rst has priority over abort, and abort has priority over start.
//  - IDLE: outputs 0. If start or AUTO_RESTART, go to DIVIDE and set k=0.
//  - DIVIDE (1 cycle): divide_en=1. Then go to ADJUST.
//  - ADJUST (1 cycle): adjust_en=1, adjust_idx=k. Then go to REFRESH with r=0.
//  - REFRESH: refresh_en=1 and adjust_idx=k. If r<REFRESH_CYCLES-1, increment r and stay.
//    Otherwise go to ADDRESS if k==SHARES-1; else increment k and go to ADJUST.
//  - ADDRESS (1 cycle): address_en=1. Then go to DONE.
//  - DONE (1 cycle): done=1, busy=0. If start or AUTO_RESTART, go to DIVIDE with k=0
//    (back-to-back operation, no idle gap). Otherwise go to IDLE.
//  - Mutual exclusion: at most one of divide_en, adjust_en, refresh_en, address_en and
//    done is high in any cycle.
//  - Latency: with start sampled at edge T, DIVIDE occupies cycle T+1 and done is high
//    in cycle T+3+SHARES*(1+REFRESH_CYCLES). For SHARES=4, REFRESH_CYCLES=1: done in T+11.
//  - start while busy is ignored. It is not queued.
//  - abort in any busy state: next cycle state=IDLE, k=0, r=0, all outputs 0. No done.
//    abort in IDLE or DONE also forces IDLE and suppresses a concurrent start.
//  - The k and r counters never wrap: k saturates at SHARES-1 and r at REFRESH_CYCLES-1
//    by construction.
//  - adjust_idx is zero-extended from k.
//  - Illegal or unused state encodings recover to IDLE on the next clock.
// TESTING
//  1. Defaults; rst for 2 cycles, then 1-cycle start pulse.
//     -> divide@T+1; adjust idx 0,1,2,3 @T+2/4/6/8; refresh @T+3/5/7/9;
//     address@T+10; done@T+11.
//  2. Hold start high through DONE.
//     -> a second DIVIDE immediately follows done; no IDLE cycle between sequences.
//  3. SHARES=3, REFRESH_CYCLES=3.
//     -> each refresh_en burst lasts exactly 3 cycles; adjust_idx runs 0..2;
//     done at T+15.
//  4. Assert abort during the REFRESH of k=2.
//     -> next cycle all outputs 0, busy=0, no done; a following start restarts at idx 0.
//  5. Assert rst during ADJUST with start also high.
//     -> next cycle IDLE, all outputs 0, and start is ignored that cycle.
//  6. AUTO_RESTART=1, start tied low.
//     -> continuous sequences with period 3+SHARES*(1+REFRESH_CYCLES).
//     Check every cycle: one-hot mutual exclusion holds, and busy is never high
//     together with done.

Source files
------------

// File: rtl/masked_share_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : masked_share_sequencer_if
//  Description : Handshake and control bundle between the round controller
//                (master) and the masked share sequencer (slave).
//                Suffixes are relative to the sequencer.
//  Signals     : start_i, abort_i              request / abort from controller
//                busy_o, done_o                 sequence status
//                divide_en_o, adjust_en_o,
//                refresh_en_o, address_en_o     datapath phase enables
//                adjust_idx_o [IDX_W]           share index in use
//  Revision    : 1.0  initial release
// ============================================================================
interface masked_share_sequencer_if #(
   parameter int IDX_W = 3
);
   logic             start_i;
   logic             abort_i;
   logic             busy_o;
   logic             done_o;
   logic             divide_en_o;
   logic             adjust_en_o;
   logic [IDX_W-1:0] adjust_idx_o;
   logic             refresh_en_o;
   logic             address_en_o;

   modport master (
      output start_i, abort_i,
      input  busy_o, done_o, divide_en_o, adjust_en_o, adjust_idx_o,
             refresh_en_o, address_en_o
   );

   modport slave (
      input  start_i, abort_i,
      output busy_o, done_o, divide_en_o, adjust_en_o, adjust_idx_o,
             refresh_en_o, address_en_o
   );
endinterface
`default_nettype wire

// File: rtl/masked_share_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : masked_share_sequencer
//  Description : Control FSM for the masked S-box datapath. A start request
//                runs DIVIDE, then ADJUST + REFRESH for every share, then
//                ADDRESS and a one-cycle DONE. Supports abort, a configurable
//                share count, refresh length and free-running restart.
//  Ports       : clk          clock, rising edge
//                rst          synchronous active-high reset
//                bus (slave)  start/abort in; busy, done, phase enables and
//                             adjust_idx out (see masked_share_sequencer_if)
//  Parameters  : SHARES (2..2**IDX_W), IDX_W, REFRESH_CYCLES (>=1),
//                AUTO_RESTART (1 = DONE/IDLE restart without start)
//  Revision    : 1.0  initial release
// ============================================================================
module masked_share_sequencer #(
   parameter int SHARES         = 4,
   parameter int IDX_W          = 3,
   parameter int REFRESH_CYCLES = 1,
   parameter int AUTO_RESTART   = 0
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   masked_share_sequencer_if.slave   bus
);

   localparam int               RW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(SHARES - 1);
   localparam logic [RW-1:0]    R_LAST = RW'(REFRESH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DIVIDE  = 3'd1,
      S_ADJUST  = 3'd2,
      S_REFRESH = 3'd3,
      S_ADDRESS = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [RW-1:0]    r_q, r_d;
   logic             restart_w;

   // Free-running mode behaves as if start were permanently asserted.
   assign restart_w = bus.start_i | (AUTO_RESTART != 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         r_q     <= r_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      case (state_q)
         S_IDLE: begin
            k_d = '0;
            r_d = '0;
            if (restart_w) state_d = S_DIVIDE;
         end
         S_DIVIDE: begin
            state_d = S_ADJUST;
         end
         S_ADJUST: begin
            r_d     = '0;
            state_d = S_REFRESH;
         end
         S_REFRESH: begin
            // r and k only advance below their last value, so neither wraps.
            if (r_q != R_LAST) begin
               r_d = r_q + RW'(1);
            end else if (k_q == K_LAST) begin
               state_d = S_ADDRESS;
            end else begin
               k_d     = k_q + IDX_W'(1);
               state_d = S_ADJUST;
            end
         end
         S_ADDRESS: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            // Counters cleared here so IDLE and a back-to-back DIVIDE both
            // start from share 0.
            k_d     = '0;
            r_d     = '0;
            state_d = restart_w ? S_DIVIDE : S_IDLE;
         end
         default: begin
            k_d     = '0;
            r_d     = '0;
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides any transition, including a start seen in IDLE/DONE.
      if (bus.abort_i) begin
         state_d = S_IDLE;
         k_d     = '0;
         r_d     = '0;
      end
   end

   // Moore decode: outputs depend only on registered state and k.
   always_comb begin
      bus.busy_o       = 1'b0;
      bus.done_o       = 1'b0;
      bus.divide_en_o  = 1'b0;
      bus.adjust_en_o  = 1'b0;
      bus.refresh_en_o = 1'b0;
      bus.address_en_o = 1'b0;
      bus.adjust_idx_o = '0;
      case (state_q)
         S_DIVIDE: begin
            bus.busy_o      = 1'b1;
            bus.divide_en_o = 1'b1;
         end
         S_ADJUST: begin
            bus.busy_o       = 1'b1;
            bus.adjust_en_o  = 1'b1;
            bus.adjust_idx_o = k_q;
         end
         S_REFRESH: begin
            bus.busy_o       = 1'b1;
            bus.refresh_en_o = 1'b1;
            bus.adjust_idx_o = k_q;
         end
         S_ADDRESS: begin
            bus.busy_o       = 1'b1;
            bus.address_en_o = 1'b1;
         end
         S_DONE: begin
            bus.done_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_masked_share_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_masked_share_sequencer
//  Description : Self-checking bench for masked_share_sequencer. Three DUTs:
//                defaults, SHARES=3/REFRESH_CYCLES=3, and free-running.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_masked_share_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;

   always #5 clk = ~clk;

   masked_share_sequencer_if #(.IDX_W(3)) bus0 ();
   masked_share_sequencer_if #(.IDX_W(3)) bus1 ();
   masked_share_sequencer_if #(.IDX_W(3)) bus2 ();

   assign bus0.start_i = start;
   assign bus0.abort_i = abort;
   assign bus1.start_i = start;
   assign bus1.abort_i = abort;
   assign bus2.start_i = 1'b0;
   assign bus2.abort_i = 1'b0;

   masked_share_sequencer #(.SHARES(4), .IDX_W(3), .REFRESH_CYCLES(1), .AUTO_RESTART(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   masked_share_sequencer #(.SHARES(3), .IDX_W(3), .REFRESH_CYCLES(3), .AUTO_RESTART(0))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));
   masked_share_sequencer #(.SHARES(4), .IDX_W(3), .REFRESH_CYCLES(1), .AUTO_RESTART(1))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Output vector layout: {busy, done, divide, adjust, refresh, address, idx[7:0]}
   logic [13:0] act0, act1, act2;
   assign act0 = {bus0.busy_o, bus0.done_o, bus0.divide_en_o, bus0.adjust_en_o,
                  bus0.refresh_en_o, bus0.address_en_o, 5'd0, bus0.adjust_idx_o};
   assign act1 = {bus1.busy_o, bus1.done_o, bus1.divide_en_o, bus1.adjust_en_o,
                  bus1.refresh_en_o, bus1.address_en_o, 5'd0, bus1.adjust_idx_o};
   assign act2 = {bus2.busy_o, bus2.done_o, bus2.divide_en_o, bus2.adjust_en_o,
                  bus2.refresh_en_o, bus2.address_en_o, 5'd0, bus2.adjust_idx_o};

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [13:0] pk(input logic b, input logic d, input logic dv,
                                      input logic a, input logic rf, input logic ad,
                                      input int idx);
      return {b, d, dv, a, rf, ad, 8'(idx)};
   endfunction

   // Reference model: a sequence is a timeline of length 3+S*(1+R) cycles.
   // pos = -1 is idle; otherwise pos is the cycle offset within the sequence.
   function automatic logic [13:0] model_out(input int pos, input int s, input int r);
      int len, p;
      len = 3 + s * (1 + r);
      if (pos < 0) return '0;
      if (pos == 0) return pk(1, 0, 1, 0, 0, 0, 0);
      if (pos <= s * (1 + r)) begin
         p = pos - 1;
         if (p % (1 + r) == 0) return pk(1, 0, 0, 1, 0, 0, p / (1 + r));
         return pk(1, 0, 0, 0, 1, 0, p / (1 + r));
      end
      if (pos == len - 2) return pk(1, 0, 0, 0, 0, 1, 0);
      return pk(0, 1, 0, 0, 0, 0, 0);
   endfunction

   function automatic int next_pos(input int pos, input logic r, input logic ab,
                                   input logic st, input bit auto_r, input int len);
      if (r || ab) return -1;
      if (pos < 0 || pos == len - 1) return (st || auto_r) ? 0 : -1;
      return pos + 1;
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_inv(input string name, input logic [13:0] act);
      n_checks++;
      if ($countones(act[12:8]) > 1 || (act[13] && act[12])) begin
         n_fail++;
         $display("FAIL %s: got %h expected one-hot phases and not busy&done", name, act);
      end
   endtask

   int pos0 = -1, pos1 = -1, pos2 = -1;
   int cyc = 0;
   int last_done2 = -1;

   task automatic tick();
      logic r_s, a_s, s_s;
      @(posedge clk);
      r_s = rst; a_s = abort; s_s = start;
      pos0 = next_pos(pos0, r_s, a_s, s_s, 1'b0, 11);
      pos1 = next_pos(pos1, r_s, a_s, s_s, 1'b0, 15);
      pos2 = next_pos(pos2, r_s, 1'b0, 1'b0, 1'b1, 11);
      #1;
      cyc++;
      check("dut0_model", act0, model_out(pos0, 4, 1));
      check("dut1_model", act1, model_out(pos1, 3, 3));
      check("dut2_model", act2, model_out(pos2, 4, 1));
      check_inv("dut0_excl", act0);
      check_inv("dut1_excl", act1);
      check_inv("dut2_excl", act2);
      if (r_s) last_done2 = -1;
      if (bus2.done_o) begin
         if (last_done2 >= 0) check_int("dut2_period", cyc - last_done2, 11);
         last_done2 = cyc;
      end
   endtask

   typedef struct {
      logic        st;
      logic        ab;
      logic [13:0] exp;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int n, rcnt;

      // Defaults sequence, back-to-back start in DONE, start ignored while
      // busy, abort suppresses a concurrent start.
      tbl[0]  = '{1, 0, pk(1,0,1,0,0,0,0)};
      tbl[1]  = '{0, 0, pk(1,0,0,1,0,0,0)};
      tbl[2]  = '{0, 0, pk(1,0,0,0,1,0,0)};
      tbl[3]  = '{0, 0, pk(1,0,0,1,0,0,1)};
      tbl[4]  = '{0, 0, pk(1,0,0,0,1,0,1)};
      tbl[5]  = '{0, 0, pk(1,0,0,1,0,0,2)};
      tbl[6]  = '{0, 0, pk(1,0,0,0,1,0,2)};
      tbl[7]  = '{0, 0, pk(1,0,0,1,0,0,3)};
      tbl[8]  = '{0, 0, pk(1,0,0,0,1,0,3)};
      tbl[9]  = '{0, 0, pk(1,0,0,0,0,1,0)};
      tbl[10] = '{0, 0, pk(0,1,0,0,0,0,0)};
      tbl[11] = '{1, 0, pk(1,0,1,0,0,0,0)};
      tbl[12] = '{1, 0, pk(1,0,0,1,0,0,0)};
      tbl[13] = '{1, 1, pk(0,0,0,0,0,0,0)};
      tbl[14] = '{0, 0, pk(0,0,0,0,0,0,0)};
      tbl[15] = '{1, 1, pk(0,0,0,0,0,0,0)};
      tbl[16] = '{1, 0, pk(1,0,1,0,0,0,0)};
      tbl[17] = '{0, 0, pk(1,0,0,1,0,0,0)};
      tbl[18] = '{0, 1, pk(0,0,0,0,0,0,0)};

      // Reset for two cycles
      rst = 1'b1;
      tick();
      tick();
      check("reset_state", act0, '0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         start = tbl[i].st;
         abort = tbl[i].ab;
         tick();
         check($sformatf("table_%0d", i), act0, tbl[i].exp);
      end
      start = 1'b0;
      abort = 1'b0;

      // SHARES=3, REFRESH_CYCLES=3: done at T+15, nine refresh cycles total
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      rcnt = (bus1.refresh_en_o) ? 1 : 0;
      while (!bus1.done_o && n < 40) begin
         tick();
         n++;
         if (bus1.refresh_en_o) rcnt++;
      end
      check_int("dut1_done_latency", n, 15);
      check_int("dut1_refresh_cycles", rcnt, 9);
      tick();

      // Abort during REFRESH of share 2
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("refresh_k2", act0, pk(1,0,0,0,1,0,2));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("after_abort", act0, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_done_after_abort", act0, '0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_divide", act0, pk(1,0,1,0,0,0,0));
      tick();
      check("restart_idx0", act0, pk(1,0,0,1,0,0,0));
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Reset during ADJUST with start held high
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_adjust", act0, pk(1,0,0,1,0,0,0));
      rst = 1'b1;
      start = 1'b1;
      tick();
      check("rst_in_adjust", act0, '0);
      rst = 1'b0;
      start = 1'b0;
      tick();
      check("start_ignored_in_rst", act0, '0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(3) == 0);
         abort = ($urandom_range(19) == 0);
         rst   = ($urandom_range(99) == 0);
         tick();
      end
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 30; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
